// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, FSM state type and helpers
package alu_pkg;

    localparam int CTRL_W  = 4;
    localparam int SHAMT_W = 5;
    localparam int STATE_W = 2;

    localparam logic [CTRL_W-1:0] ALU_ADD = 4'd0;
    localparam logic [CTRL_W-1:0] ALU_SUB = 4'd1;
    localparam logic [CTRL_W-1:0] ALU_AND = 4'd3;
    localparam logic [CTRL_W-1:0] ALU_OR  = 4'd4;
    localparam logic [CTRL_W-1:0] ALU_XOR = 4'd5;
    localparam logic [CTRL_W-1:0] ALU_LUI = 4'd6;
    localparam logic [CTRL_W-1:0] ALU_SLL = 4'd7;
    localparam logic [CTRL_W-1:0] ALU_SRL = 4'd8;
    localparam logic [CTRL_W-1:0] ALU_SRA = 4'd9;
    localparam logic [CTRL_W-1:0] ALU_NOR = 4'd11;
    localparam logic [CTRL_W-1:0] ALU_SLT = 4'd12;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [CTRL_W-1:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// rtl/alu_seq_comb.sv - single-cycle ALU datapath and result flags
module alu_seq_comb
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              ovf,
    output logic              illegal
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // Shift codes reaching this path have a zero shift amount, so they pass b through.
    always_comb begin
        result  = '0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (alu_ctrl)
            ALU_ADD: begin
                result = sum;
                ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                result = diff;
                ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_LUI: result = {b[DATA_W-17:0], 16'h0000};
            ALU_SLL, ALU_SRL, ALU_SRA: result = b;
            ALU_NOR: result = ~(a | b);
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: illegal = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - execute-stage ALU with iterative shifter and valid/ready output
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  alu_ctrl,
    input  logic [DATA_W-1:0]  op_a,
    input  logic [DATA_W-1:0]  op_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic               zero,
    output logic               ovf,
    output logic               illegal
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   sreg_q, sreg_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic                sign_q, sign_d;
    logic [CTRL_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                zero_q, zero_d;
    logic                ovf_q, ovf_d;
    logic                illegal_q, illegal_d;

    logic [DATA_W-1:0]   c_result;
    logic                c_zero, c_ovf, c_illegal;
    logic [DATA_W-1:0]   shifted;
    logic                accept;

    alu_seq_comb #(.DATA_W(DATA_W)) u_comb (
        .alu_ctrl (alu_ctrl),
        .a        (op_a),
        .b        (op_b),
        .result   (c_result),
        .zero     (c_zero),
        .ovf      (c_ovf),
        .illegal  (c_illegal)
    );

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign illegal   = illegal_q;

    // SRA fills from the sign captured at acceptance, not from the moving register.
    always_comb begin
        case (op_q)
            ALU_SLL: shifted = {sreg_q[DATA_W-2:0], 1'b0};
            ALU_SRA: shifted = {sign_q, sreg_q[DATA_W-1:1]};
            default: shifted = {1'b0, sreg_q[DATA_W-1:1]};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        op_d      = op_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;

        case (state_q)
            ST_SHIFT: begin
                sreg_d = shifted;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d  = shifted;
                    zero_d    = (shifted == '0);
                    ovf_d     = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Acceptance from IDLE and back-to-back acceptance from DONE share one path.
        if (accept) begin
            if (is_shift(alu_ctrl) && (shamt != '0)) begin
                sreg_d  = op_b;
                cnt_d   = shamt;
                sign_d  = op_b[DATA_W-1];
                op_d    = alu_ctrl;
                state_d = ST_SHIFT;
            end else begin
                result_d  = c_result;
                zero_d    = c_zero;
                ovf_d     = c_ovf;
                illegal_d = c_illegal;
                state_d   = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sreg_q    <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            op_q      <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            op_q      <= op_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb/tb_alu_seq_exec.sv - scoreboard bench for alu_seq_exec with directed vectors
module tb_alu_seq_exec;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        illegal;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   acc1, acc2, acc3;

    alu_seq_exec #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s, input logic [31:0] res, input logic ov,
                        input logic il);
        bit ok;
        exp_t e;
        e.res = res; e.zero = (res == 32'h0); e.ovf = ov; e.ill = il;
        exp_q.push_back(e);
        alu_ctrl = c; op_a = a; op_b = b; shamt = s; in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) fail_now("in_ready_wait");
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int lat);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        if (!ok) fail_now("out_valid_wait");
        else chk("latency", cyc - acc_cyc + 1, lat);
    endtask

    // Monitor: compares every cycle the result is presented, pops on handshake.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                fail_now("stray_out_valid");
            end else begin
                mon_e = exp_q[0];
                chk("result", result, mon_e.res);
                chk("zero", {31'b0, zero}, {31'b0, mon_e.zero});
                chk("ovf", {31'b0, ovf}, {31'b0, mon_e.ovf});
                chk("illegal", {31'b0, illegal}, {31'b0, mon_e.ill});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alu_ctrl = '0; op_a = '0; op_b = '0; shamt = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_zero", {31'b0, zero}, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        step();
        rst = 1'b0;
        step();

        send(ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b1, 1'b0);
        wait_out(1); step();
        send(ALU_SUB, 32'd5, 32'd5, 5'd0, 32'h0, 1'b0, 1'b0);
        wait_out(1); step();
        send(ALU_SUB, 32'h80000000, 32'd1, 5'd0, 32'h7FFFFFFF, 1'b1, 1'b0);
        wait_out(1); step();

        // Inputs changed during SHIFT must not disturb the result.
        send(ALU_SRA, 32'h0, 32'h80000010, 5'd4, 32'hF8000001, 1'b0, 1'b0);
        op_b = 32'h0; shamt = 5'd1; alu_ctrl = ALU_ADD;
        wait_out(5); step();
        send(ALU_SLL, 32'h0, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0);
        wait_out(32); step();
        send(ALU_SRL, 32'h0, 32'h80000000, 5'd4, 32'h08000000, 1'b0, 1'b0);
        wait_out(5); step();
        send(ALU_SLL, 32'h0, 32'h000000A5, 5'd0, 32'h000000A5, 1'b0, 1'b0);
        wait_out(1); step();

        send(ALU_AND, 32'hF0F01234, 32'h0FF0FF00, 5'd0, 32'h00F01200, 1'b0, 1'b0);
        acc1 = acc_cyc;
        send(ALU_OR, 32'hF0000000, 32'h0000000F, 5'd0, 32'hF000000F, 1'b0, 1'b0);
        acc2 = acc_cyc;
        send(ALU_SLT, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, 1'b0, 1'b0);
        acc3 = acc_cyc;
        chk("b2b_gap1", acc2 - acc1, 32'd1);
        chk("b2b_gap2", acc3 - acc2, 32'd1);
        step(); step();

        out_ready = 1'b0;
        send(ALU_LUI, 32'h0, 32'h00001234, 5'd0, 32'h12340000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_release", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        chk("bp_consumed", {31'b0, out_valid}, 32'd0);
        step();

        send(4'd13, 32'h12345678, 32'h9ABCDEF0, 5'd0, 32'h0, 1'b0, 1'b1);
        wait_out(1); step();
        send(4'd2, 32'h1, 32'h1, 5'd0, 32'h0, 1'b0, 1'b1);
        wait_out(1); step();
        send(ALU_NOR, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        wait_out(1); step();
        send(ALU_XOR, 32'hAAAA5555, 32'hFFFF0000, 5'd0, 32'h55555555, 1'b0, 1'b0);
        wait_out(1); step();
        send(ALU_SLT, 32'h00000001, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b0, 1'b0);
        wait_out(1); step();

        // Reset during the 3rd cycle of a long shift discards the operation.
        send(ALU_SLL, 32'h0, 32'h00000003, 5'd10, 32'h00000C00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_result", result, 32'h0);
        chk("mid_rst_zero", {31'b0, zero}, 32'd0);
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_no_valid", {31'b0, out_valid}, 32'd0);
        end
        step();
        send(ALU_ADD, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1'b0);
        wait_out(1); step();

        repeat (3) step();
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
